// File: rtl/muldiv_unit_if.sv
// Operand, control and result bundle between the EX stage and muldiv_unit.
// The CPU side uses the master modport; the unit uses the slave modport.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle combinational multiply.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r, lo_r;

    // Operand/result datapath; never reset, only loaded on launch.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 is_div, is_sgn, div0, sign_q, sign_r;

    logic                 start_ok, launch;
    logic [WIDTH-1:0]     mul_add;
    logic [WIDTH:0]       mul_sum, div_part, div_trial;
    logic [2*WIDTH-1:0]   acc_step, prod;
    logic [WIDTH-1:0]     res_hi, res_lo;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v) + WIDTH'(1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v) + (2*WIDTH)'(1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return neg_w(v, sgn & v[WIDTH-1]);
    endfunction

    assign start_ok = (state == IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MULT_EN
    logic               fast_mul, fast_sgn;
    logic [2*WIDTH-1:0] fast_mag, fast_prod;

    assign fast_mul  = start_ok && !bus.op[1];
    assign launch    = start_ok && bus.op[1];
    assign fast_sgn  = !bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    assign fast_mag  = {{WIDTH{1'b0}}, mag(bus.a, !bus.op[0])} *
                       {{WIDTH{1'b0}}, mag(bus.b, !bus.op[0])};
    assign fast_prod = neg_2w(fast_mag, fast_sgn);
`else
    assign launch    = start_ok;
`endif

    // One shift-add or restoring-subtract step on the shared accumulator.
    always_comb begin
        mul_add   = acc[0] ? opb : {WIDTH{1'b0}};
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        div_part  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_part - {1'b0, opb};
        if (is_div) begin
            if (div_trial[WIDTH])
                acc_step = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied on the way into HI/LO.
    always_comb begin
        prod = neg_2w(acc, is_sgn & sign_q);
        if (is_div) begin
            res_hi = neg_w(acc[2*WIDTH-1:WIDTH], is_sgn & sign_r);
            res_lo = div0 ? {WIDTH{1'b1}} : neg_w(acc[WIDTH-1:0], is_sgn & sign_q);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = ITER;
            ITER: begin
                if (bus.flush)                          state_nx = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))      state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef MULDIV_FAST_MULT_EN
                    if (fast_mul) begin
                        hi_r   <= fast_prod[2*WIDTH-1:WIDTH];
                        lo_r   <= fast_prod[WIDTH-1:0];
                        done_r <= 1'b1;
                    end else
`endif
                    if (!bus.start) begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                ITER: cnt <= cnt + CNT_W'(1);
                FIX: begin
                    if (!bus.flush) begin
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                        done_r <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            acc    <= {{WIDTH{1'b0}}, mag(bus.a, !bus.op[0])};
            opb    <= mag(bus.b, !bus.op[0]);
            is_div <= bus.op[1];
            is_sgn <= !bus.op[0];
            div0   <= (bus.b == '0);
            sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_r <= bus.a[WIDTH-1];
        end else if (state == ITER) begin
            acc    <= acc_step;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, HI/LO writes, flush and reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.hi !== 32'h0)  begin failures++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0)  begin failures++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int cyc, bcyc, exp_cyc;
        exp_cyc = 33;
`ifdef MULDIV_FAST_MULT_EN
        if (!op[1]) exp_cyc = 0;
`endif
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0; bcyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) bcyc++;
            tick();
            cyc++;
        end
        checks++; if (cyc != exp_cyc)     begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_cyc); end
        checks++; if (bcyc != exp_cyc)    begin failures++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcyc, exp_cyc); end
        checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL %s_busy_at_done: got %b expected 0", name, bus.busy); end
        checks++; if (bus.hi !== exp_hi)  begin failures++; $display("FAIL %s_hi: got %h expected %h", name, bus.hi, exp_hi); end
        checks++; if (bus.lo !== exp_lo)  begin failures++; $display("FAIL %s_lo: got %h expected %h", name, bus.lo, exp_lo); end
        tick();
        checks++; if (bus.done !== 1'b0)  begin failures++; $display("FAIL %s_done_pulse: got %b expected 0", name, bus.done); end
    endtask

    task automatic test_mul;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, "mult_negneg");
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
    endtask

    task automatic test_div;
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor");
        run_op(2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_basic");
        run_op(2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_zero");
        run_op(2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_one");
    endtask

    task automatic test_mthi_mtlo;
        bus.hi_we = 1'b1; bus.wdata = 32'h00001234;
        tick();
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h00001234) begin failures++; $display("FAIL mthi: got %h expected 00001234", bus.hi); end
        checks++; if (bus.done !== 1'b0)       begin failures++; $display("FAIL mthi_done: got %b expected 0", bus.done); end
        bus.lo_we = 1'b1; bus.wdata = 32'h00005678;
        tick();
        bus.lo_we = 1'b0;
        checks++; if (bus.lo !== 32'h00005678) begin failures++; $display("FAIL mtlo: got %h expected 00005678", bus.lo); end
        checks++; if (bus.hi !== 32'h00001234) begin failures++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", bus.hi); end
    endtask

    task automatic test_ignore_mid_op;
        logic [31:0] pre_lo;
        int cyc;
        pre_lo = bus.lo;
        bus.op = 2'b10; bus.a = 32'hFFFFFFF9; bus.b = 32'h00000002; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        repeat (5) begin tick(); cyc++; end
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        tick(); cyc++;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        checks++; if (bus.lo !== pre_lo)  begin failures++; $display("FAIL busy_lo_we: got %h expected %h", bus.lo, pre_lo); end
        checks++; if (bus.busy !== 1'b1)  begin failures++; $display("FAIL busy_restart: got %b expected 1", bus.busy); end
        while (bus.done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        checks++; if (cyc != 33)              begin failures++; $display("FAIL midop_latency: got %0d expected 33", cyc); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL midop_hi: got %h expected ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL midop_lo: got %h expected fffffffd", bus.lo); end
        tick();
    endtask

    task automatic test_start_wins;
        logic [31:0] pre_hi;
        int cyc;
        pre_hi = bus.hi;
        bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000CAFE;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        checks++; if (bus.hi !== pre_hi)  begin failures++; $display("FAIL start_wins_hi: got %h expected %h", bus.hi, pre_hi); end
        checks++; if (bus.busy !== 1'b1)  begin failures++; $display("FAIL start_wins_busy: got %b expected 1", bus.busy); end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        checks++; if (bus.hi !== 32'd1) begin failures++; $display("FAIL start_wins_rem: got %h expected 1", bus.hi); end
        checks++; if (bus.lo !== 32'd4) begin failures++; $display("FAIL start_wins_quo: got %h expected 4", bus.lo); end
        tick();
    endtask

    task automatic test_flush;
        bit saw_done;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000AAAA; tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000BBBB; tick();
        bus.lo_we = 1'b0;
        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)       begin failures++; $display("FAIL flush_done: got %b expected 0", bus.done); end
        checks++; if (bus.hi !== 32'h0000AAAA) begin failures++; $display("FAIL flush_hi: got %h expected 0000aaaa", bus.hi); end
        checks++; if (bus.lo !== 32'h0000BBBB) begin failures++; $display("FAIL flush_lo: got %h expected 0000bbbb", bus.lo); end
        saw_done = 1'b0;
        repeat (40) begin tick(); if (bus.done === 1'b1) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0)       begin failures++; $display("FAIL flush_late_done: got %b expected 0", saw_done); end
        checks++; if (bus.lo !== 32'h0000BBBB) begin failures++; $display("FAIL flush_lo_late: got %h expected 0000bbbb", bus.lo); end
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd5; bus.b = 32'd1;
        tick();
        bus.flush = 1'b0; bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy: got %b expected 0", bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_start_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_reset_mid_op;
        bus.op = 2'b10; bus.a = 32'hFFFFFFF9; bus.b = 32'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.hi !== 32'h0)  begin failures++; $display("FAIL midrst_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0)  begin failures++; $display("FAIL midrst_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_back_to_back;
        run_op(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "b2b_multu");
        run_op(2'b10, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, "b2b_div");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mthi_mtlo();
        test_ignore_mid_op();
        test_start_wins();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
